// File: rtl/test_monitor.sv
// test_monitor: watches core writeback and retire traffic and decides the test verdict.
// An ecall that retires while gp is odd ends the test: gp==1 is a pass, any other odd
// value is a failure that reports test number gp[31:1]. If no verdict arrives within
// TIMEOUT_CYCLES, the monitor declares a timeout. The verdict outputs are registered
// and appear on the clock edge that follows the deciding cycle.
//
// Optional feature: define TEST_MONITOR_STALL_DETECT_EN to enable stall detection.
// With it, repeated retires of the same PC end the test as a failure with stalled=1.
//
// Ports:
//   clk, rst (synchronous, active-low)
//   wb_en/wb_addr/wb_data       register-file write port (only x3 is observed)
//   ret_valid/ret_pc/ret_instr  retire port
//   done/pass/fail/timeout/stalled/fail_testnum/cycles  verdict outputs
module test_monitor #(
  parameter int TIMEOUT_CYCLES = 5000,
  parameter int STALL_CYCLES   = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wb_en,
  input  logic [4:0]  wb_addr,
  input  logic [31:0] wb_data,
  input  logic        ret_valid,
  input  logic [31:0] ret_pc,
  input  logic [31:0] ret_instr,
  output logic        done,
  output logic        pass,
  output logic        fail,
  output logic        timeout,
  output logic        stalled,
  output logic [30:0] fail_testnum,
  output logic [31:0] cycles
);

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_PASS    = 2'd1,
    ST_FAIL    = 2'd2,
    ST_TIMEOUT = 2'd3
  } state_t;

  localparam logic [31:0] ECALL_INSN   = 32'h0000_0073;
  localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);

  state_t      state;
  state_t      state_next;
  logic [31:0] gp_shadow;
  logic [31:0] gp_eff;
  logic        gp_wr;
  logic        ecall;
  logic        ecall_pass;
  logic        ecall_fail;
  logic        timeout_hit;
  logic        stall_hit;
  logic [30:0] testnum_q;

  // A gp write in the same cycle as the ecall is forwarded, so the verdict
  // reflects the final gp value even before it lands in the shadow register.
  assign gp_wr       = wb_en && (wb_addr == 5'd3);
  assign gp_eff      = gp_wr ? wb_data : gp_shadow;
  assign ecall       = ret_valid && (ret_instr == ECALL_INSN);
  assign ecall_pass  = ecall && (gp_eff == 32'd1);
  assign ecall_fail  = ecall && gp_eff[0] && (gp_eff != 32'd1);
  assign timeout_hit = (cycles == TIMEOUT_LAST);

`ifdef TEST_MONITOR_STALL_DETECT_EN
  localparam logic [31:0] STALL_LIM = 32'(STALL_CYCLES);

  logic [31:0] last_pc;
  logic [31:0] stall_cnt;
  logic [31:0] stall_cnt_nxt;
  logic        stall_take;
  logic        stalled_q;

  // The hit is judged on the count this retire produces, so the Nth
  // repeat ends the test on the same edge at which it is counted.
  always_comb begin
    stall_cnt_nxt = stall_cnt;
    if (ret_valid) begin
      if (ret_pc == last_pc) begin
        stall_cnt_nxt = (stall_cnt == 32'hFFFF_FFFF) ? stall_cnt : stall_cnt + 32'd1;
      end else begin
        stall_cnt_nxt = 32'd0;
      end
    end
  end

  assign stall_hit  = (stall_cnt_nxt >= STALL_LIM);
  // A stall counts only when no ecall verdict and no timeout compete in the same cycle.
  assign stall_take = stall_hit && !ecall_pass && !ecall_fail && !timeout_hit;

  always_ff @(posedge clk) begin
    if (!rst) begin
      last_pc   <= 32'd0;
      stall_cnt <= 32'd0;
      stalled_q <= 1'b0;
    end else if (state == ST_RUN) begin
      if (ret_valid) begin
        last_pc <= ret_pc;
      end
      stall_cnt <= stall_cnt_nxt;
      if (stall_take) begin
        stalled_q <= 1'b1;
      end
    end
  end

  assign stalled = stalled_q;
`else
  logic unused_stall_inputs;

  assign stall_hit           = 1'b0;
  assign stalled             = 1'b0;
  assign unused_stall_inputs = ^{ret_pc, 32'(STALL_CYCLES)};
`endif

  // State register
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= ST_RUN;
    end else begin
      state <= state_next;
    end
  end

  // Next state: ecall verdict beats timeout, and timeout beats stall.
  always_comb begin
    state_next = state;
    if (state == ST_RUN) begin
      if (ecall_pass) begin
        state_next = ST_PASS;
      end else if (ecall_fail) begin
        state_next = ST_FAIL;
      end else if (timeout_hit) begin
        state_next = ST_TIMEOUT;
      end else if (stall_hit) begin
        state_next = ST_FAIL;
      end
    end
  end

  // Verdict outputs, decoded from the registered state
  always_comb begin
    done    = (state != ST_RUN);
    pass    = (state == ST_PASS);
    fail    = (state == ST_FAIL) || (state == ST_TIMEOUT);
    timeout = (state == ST_TIMEOUT);
  end

  // Datapath. Nothing updates once a verdict is held. The cycle count stops on
  // the edge that leaves RUN, which keeps the value from the deciding cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      gp_shadow <= 32'd0;
      cycles    <= 32'd0;
      testnum_q <= 31'd0;
    end else if (state == ST_RUN) begin
      if (gp_wr) begin
        gp_shadow <= wb_data;
      end
      if ((state_next == ST_RUN) && (cycles != 32'hFFFF_FFFF)) begin
        cycles <= cycles + 32'd1;
      end
      if (ecall_fail) begin
        testnum_q <= gp_eff[31:1];
      end
    end
  end

  assign fail_testnum = testnum_q;

endmodule
